// File: rtl/mdu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mdu_pkg                                                       |
// | Purpose  : Shared encodings for the multiply/divide unit: md_op codes     |
// |            (also decoded by the hazard unit) and controller FSM states.  |
// | Ports    : none (package)                                                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package mdu_pkg;

   typedef enum logic [3:0] {
      MD_NONE  = 4'd0,
      MD_MULT  = 4'd1,
      MD_MULTU = 4'd2,
      MD_DIV   = 4'd3,
      MD_DIVU  = 4'd4,
      MD_MFHI  = 4'd5,
      MD_MFLO  = 4'd6,
      MD_MTHI  = 4'd7,
      MD_MTLO  = 4'd8
   } md_op_e;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_MUL_RUN = 2'd1,
      ST_DIV_RUN = 2'd2
   } mdu_state_e;

   // True for the four multi-cycle arithmetic ops; any other code, including
   // unused ones, behaves like MD_NONE as far as starting is concerned.
   function automatic logic is_arith(logic [3:0] op);
      return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
   endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mdu_if                                                        |
// | Purpose  : E-stage <-> multiply/divide unit bundle.                       |
// | Ports    : md_valid, md_op, rs_val, rt_val  (E-stage -> mdu)             |
// |            md_start, busy, md_rdata         (mdu -> E-stage / hazard)    |
// |            master = E-stage side, slave = mdu side                       |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface mdu_if #(
   parameter int WIDTH = 32
);
   logic             md_valid;
   logic [3:0]       md_op;
   logic [WIDTH-1:0] rs_val;
   logic [WIDTH-1:0] rt_val;
   logic             md_start;
   logic             busy;
   logic [WIDTH-1:0] md_rdata;

   modport master (
      output md_valid, md_op, rs_val, rt_val,
      input  md_start, busy, md_rdata
   );

   modport slave (
      input  md_valid, md_op, rs_val, rt_val,
      output md_start, busy, md_rdata
   );
endinterface
`default_nettype wire

// File: rtl/mdu_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mdu_counter                                                   |
// | Purpose  : Busy-cycle counter. Loads a cycle count, decrements to zero,  |
// |            and flags the last busy cycle (count == 1).                   |
// | Ports    : clk, reset (async active-low), load, load_val[CNT_W], done    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module mdu_counter #(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             done
);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (count != '0) begin
         count <= count - 1'b1;
      end
   end

   assign done = (count == {{(CNT_W-1){1'b0}}, 1'b1});

endmodule
`default_nettype wire

// File: rtl/mdu.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mdu                                                           |
// | Purpose  : Multi-cycle MULT/MULTU/DIV/DIVU into private HI/LO, plus      |
// |            MFHI/MFLO/MTHI/MTLO. busy lets the hazard unit stall.         |
// | Ports    : clk, reset (async active-low)                                 |
// |            md : mdu_if.slave (md_valid, md_op, rs_val, rt_val in;        |
// |                 md_start, busy, md_rdata out)                            |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module mdu
   import mdu_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic  clk,
   input  logic  reset,
   mdu_if.slave  md
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
   localparam logic [CNT_W-1:0] MULT_N = CNT_W'(MULT_CYCLES);
   localparam logic [CNT_W-1:0] DIV_N  = CNT_W'(DIV_CYCLES);

   mdu_state_e       state, next_state;
   logic             start;
   logic             busy;
   logic             done;
   logic             start_mul;
   logic [3:0]       op_q;
   logic [WIDTH-1:0] a_q, b_q;
   logic [WIDTH-1:0] hi, lo;

   // ---------------- controller FSM ----------------
   assign busy      = (state != ST_IDLE);
   assign start_mul = (md.md_op == MD_MULT) || (md.md_op == MD_MULTU);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= ST_IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      start      = 1'b0;
      case (state)
         ST_IDLE: begin
            start = md.md_valid && is_arith(md.md_op);
            if (start) next_state = start_mul ? ST_MUL_RUN : ST_DIV_RUN;
         end
         ST_MUL_RUN, ST_DIV_RUN: begin
            if (done) next_state = ST_IDLE;
         end
         default: next_state = ST_IDLE;
      endcase
   end

   mdu_counter #(.CNT_W(CNT_W)) u_counter (
      .clk      (clk),
      .reset    (reset),
      .load     (start),
      .load_val (start_mul ? MULT_N : DIV_N),
      .done     (done)
   );

   // ---------------- operand latch ----------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         op_q <= MD_NONE;
         a_q  <= '0;
         b_q  <= '0;
      end else if (start) begin
         op_q <= md.md_op;
         a_q  <= md.rs_val;
         b_q  <= md.rt_val;
      end
   end

   // ---------------- arithmetic on latched operands ----------------
   // Both products are formed as 2W-bit unsigned multiplies; sign-extending
   // the operands first makes the low 2W bits equal the signed product.
   logic [2*WIDTH-1:0] prod_u, prod_s;
   assign prod_u = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
   assign prod_s = {{WIDTH{a_q[WIDTH-1]}}, a_q} * {{WIDTH{b_q[WIDTH-1]}}, b_q};

   // Division runs on magnitudes and re-applies signs. This also yields the
   // MIN_INT / -1 case naturally: |MIN_INT| as unsigned is 2^(W-1), and its
   // negation wraps back to MIN_INT with a zero remainder.
   logic             div_signed, a_neg, b_neg;
   logic [WIDTH-1:0] a_mag, b_mag, b_den, q_mag, r_mag, quot, rem;

   always_comb begin
      div_signed = (op_q == MD_DIV);
      a_neg      = div_signed && a_q[WIDTH-1];
      b_neg      = div_signed && b_q[WIDTH-1];
      a_mag      = a_neg ? (~a_q + 1'b1) : a_q;
      b_mag      = b_neg ? (~b_q + 1'b1) : b_q;
      // Divisor 0 never commits; substitute 1 so the divider never sees 0.
      b_den      = (b_q == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : b_mag;
      q_mag      = a_mag / b_den;
      r_mag      = a_mag % b_den;
      quot       = (a_neg ^ b_neg) ? (~q_mag + 1'b1) : q_mag;
      rem        = a_neg ? (~r_mag + 1'b1) : r_mag;
   end

   // ---------------- HI/LO ----------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hi <= '0;
         lo <= '0;
      end else if (busy) begin
         if (done) begin
            if (state == ST_MUL_RUN) begin
               {hi, lo} <= (op_q == MD_MULT) ? prod_s : prod_u;
            end else if (b_q != '0) begin
               hi <= rem;
               lo <= quot;
            end
         end
      end else if (md.md_valid) begin
         if (md.md_op == MD_MTHI) hi <= md.rs_val;
         if (md.md_op == MD_MTLO) lo <= md.rs_val;
      end
   end

   // ---------------- outputs ----------------
   assign md.md_start = start;
   assign md.busy     = busy;
   assign md.md_rdata = (md.md_op == MD_MFHI) ? hi :
                        (md.md_op == MD_MFLO) ? lo : '0;

endmodule
`default_nettype wire
